bus_io_port: RTL and testbench
==============================

BUS_IO_PORT -- requirements
Module: bus_io_port

Interface
REQ-001 Parameter BASE_ADDR, default 16'hFF00, word address of the 4-register window; bits [1:0] SHALL be zero.
REQ-002 Parameter FIFO_DEPTH, default 4, entries per FIFO; SHALL be a power of two, 2..16.
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 notReset  input  1  asynchronous, active-low reset.
REQ-005 aBus  input  16  CPU address bus.
REQ-006 yBus  inout  16  CPU data bus; driven only during a selected read, else high-Z.
REQ-007 memNotRead  input  1  active-low CPU read strobe.
REQ-008 memNotWrite  input  1  active-low CPU write strobe.
REQ-009 txData  output  8  head of TX FIFO.
REQ-010 txValid  output  1  TX FIFO non-empty.
REQ-011 txReady  input  1  sink accepts txData when txValid and txReady high at a rising edge.
REQ-012 rxData  input  8  incoming byte.
REQ-013 rxValid  input  1  source offers rxData.
REQ-014 rxReady  output  1  RX FIFO not full; byte pushed when rxValid and rxReady high at a rising edge.

Function
REQ-015 Select = aBus[15:2] == BASE_ADDR[15:2]; offset aBus[1:0]: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved (reads 0, writes ignored).
REQ-016 Read: yBus SHALL be driven combinationally while select and memNotRead low and memNotWrite high; upper bits zero-extended.
REQ-017 DATA read returns RX head ({8'h00, byte}); 16'h0000 if RX empty.
REQ-018 STATUS read: bit0 txFull, bit1 txEmpty, bit2 rxFull, bit3 rxEmpty, bit4 txOverflow, bit5 rxUnderrun, bits[15:8] RX count, others 0.
REQ-019 CTRL read: bit3 loopback, others 0.
REQ-020 Access edge: one strobe registered per cycle; an access takes effect only on the first rising edge of a strobe-low period (falling-edge detect), so a strobe held low N cycles counts once.
REQ-021 DATA read access pops RX FIFO; if empty, no pop and rxUnderrun set.
REQ-022 DATA write access pushes yBus[7:0] to TX FIFO; if full (pre-edge state, regardless of same-edge TX pop), byte dropped and txOverflow set.
REQ-023 CTRL write: bit0 flush TX, bit1 flush RX, bit2 clear txOverflow/rxUnderrun, bit3 loopback enable; bits 0..2 self-clearing pulses; a sticky set and clear on the same edge: set wins.
REQ-024 Both strobes low with select: write performed, yBus not driven, no pop.
REQ-025 Simultaneous push and pop on the same FIFO SHALL both complete, count unchanged; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-026 Flush on the same edge as a push: flush wins, FIFO empty afterwards.

Reset
REQ-027 notReset low: both FIFOs empty, stickies 0, loopback 0, strobe history "high"; txValid 0, rxReady 1, txData 8'h00, yBus high-Z; asynchronous, release takes effect on next edge.
REQ-028 Reset mid-access discards the access; a strobe already low at release SHALL NOT count as an access.

Configuration
REQ-029 Macro BUS_IO_LOOPBACK_EN defined: CTRL bit3 set routes TX FIFO head into RX FIFO (tx port txValid forced 0, rxReady forced 0, rx port ignored), transfer at one byte per cycle when TX non-empty and RX not full.
REQ-030 Macro undefined: CTRL bit3 writes ignored, reads 0, no loopback logic.

Structure
REQ-031 Package bus_io_pkg SHALL hold register offsets, STATUS/CTRL bit positions and default BASE_ADDR.
REQ-032 Both FIFOs SHALL be instances of one sub-module sync_fifo (parameterised width/depth, push/pop/flush, full/empty/count).

Verification
REQ-033 Write 16'h0041 to FF00, txReady 0 -> txValid 1, txData 8'h41, STATUS bit1 0.
REQ-034 Five writes with DEPTH 4, txReady 0 -> fifth dropped, STATUS bit4 1; CTRL write 16'h0004 -> bit4 0.
REQ-035 Push 8'h12, 8'h34 via rx port; two DATA reads -> 16'h0012, 16'h0034; third read -> 16'h0000, bit5 1.
REQ-036 memNotRead held low 3 cycles on DATA with RX holding 2 bytes -> single pop, count 1.
REQ-037 notReset pulsed low with TX holding 3 bytes mid-write -> txValid 0, STATUS 16'h000A after release.
REQ-038 BUS_IO_LOOPBACK_EN, CTRL 16'h0008, write 16'h00AA -> next DATA read 16'h00AA, txValid stays 0.

Source files
------------

// File: rtl/bus_io_pkg.sv
// Shared register map, STATUS/CTRL bit positions and default window base for bus_io_port.
package bus_io_pkg;

  localparam logic [15:0] BASE_ADDR_DEFAULT = 16'hFF00;

  typedef enum logic [1:0] {
    OffData   = 2'd0,
    OffStatus = 2'd1,
    OffCtrl   = 2'd2,
    OffRsvd   = 2'd3
  } reg_off_e;

  localparam int unsigned StTxFull   = 0;
  localparam int unsigned StTxEmpty  = 1;
  localparam int unsigned StRxFull   = 2;
  localparam int unsigned StRxEmpty  = 3;
  localparam int unsigned StTxOvf    = 4;
  localparam int unsigned StRxUnd    = 5;
  localparam int unsigned StCountLsb = 8;

  localparam int unsigned CtrlFlushTx  = 0;
  localparam int unsigned CtrlFlushRx  = 1;
  localparam int unsigned CtrlClrErr   = 2;
  localparam int unsigned CtrlLoopback = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop/flush; head reads zero while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  // Full/empty gating uses pre-edge state, so a push into a full FIFO is lost even on a pop edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{(CW-1){1'b0}}, do_push} - {{(CW-1){1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q] <= push_data;
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/bus_io_port.sv
// Memory-mapped byte I/O port: TX/RX FIFOs behind a 4-word CPU register window.
// Optional TX-to-RX loopback is built only when BUS_IO_LOOPBACK_EN is defined.
module bus_io_port import bus_io_pkg::*; #(
  parameter logic [15:0] BASE_ADDR  = BASE_ADDR_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        notReset,
  input  logic [15:0] aBus,
  inout  wire  [15:0] yBus,
  input  logic        memNotRead,
  input  logic        memNotWrite,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txReady,
  input  logic [7:0]  rxData,
  input  logic        rxValid,
  output logic        rxReady
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          sel;
  reg_off_e      off;
  logic          rd_n_q, wr_n_q, armed_q;
  logic          wr_acc, rd_acc, data_wr, ctrl_wr, data_rd;
  logic          tx_ovf_q, rx_und_q;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]    tx_head, rx_head, rx_push_data;
  logic [CW-1:0] rx_count, tx_count_unused;
  logic          tx_pop, rx_push, loopback;
  logic [15:0]   rd_data;
  logic          unused_ybus;

  assign sel = (aBus[15:2] == BASE_ADDR[15:2]);
  assign off = reg_off_e'(aBus[1:0]);

  // armed_q keeps a strobe that is already low when reset releases from counting as an access.
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      rd_n_q  <= memNotRead;
      wr_n_q  <= memNotWrite;
      armed_q <= 1'b1;
    end
  end

  assign wr_acc  = armed_q && sel && wr_n_q && !memNotWrite;
  assign rd_acc  = armed_q && sel && rd_n_q && !memNotRead && memNotWrite;
  assign data_wr = wr_acc && (off == OffData);
  assign ctrl_wr = wr_acc && (off == OffCtrl);
  assign data_rd = rd_acc && (off == OffData);

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      tx_ovf_q <= 1'b0;
      rx_und_q <= 1'b0;
    end else begin
      if (ctrl_wr && yBus[CtrlClrErr]) begin
        tx_ovf_q <= 1'b0;
        rx_und_q <= 1'b0;
      end
      if (data_wr && tx_full)  tx_ovf_q <= 1'b1;
      if (data_rd && rx_empty) rx_und_q <= 1'b1;
    end
  end

`ifdef BUS_IO_LOOPBACK_EN
  logic loopback_q, lb_xfer;

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset)    loopback_q <= 1'b0;
    else if (ctrl_wr) loopback_q <= yBus[CtrlLoopback];
  end

  // In loopback the external ports are idle and the TX head streams straight into RX.
  assign lb_xfer      = loopback_q && !tx_empty && !rx_full;
  assign txValid      = !tx_empty && !loopback_q;
  assign rxReady      = !rx_full && !loopback_q;
  assign tx_pop       = loopback_q ? lb_xfer : (txValid && txReady);
  assign rx_push      = loopback_q ? lb_xfer : (rxValid && rxReady);
  assign rx_push_data = loopback_q ? tx_head : rxData;
  assign loopback     = loopback_q;
`else
  assign txValid      = !tx_empty;
  assign rxReady      = !rx_full;
  assign tx_pop       = txValid && txReady;
  assign rx_push      = rxValid && rxReady;
  assign rx_push_data = rxData;
  assign loopback     = 1'b0;
`endif

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clock),
    .rst_n     (notReset),
    .push      (data_wr),
    .push_data (yBus[7:0]),
    .pop       (tx_pop),
    .flush     (ctrl_wr && yBus[CtrlFlushTx]),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count_unused)
  );

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clock),
    .rst_n     (notReset),
    .push      (rx_push),
    .push_data (rx_push_data),
    .pop       (data_rd),
    .flush     (ctrl_wr && yBus[CtrlFlushRx]),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  assign txData = tx_head;

  always_comb begin
    rd_data = '0;
    unique case (off)
      OffData:   rd_data = {8'h00, rx_head};
      OffStatus: begin
        rd_data[StTxFull]           = tx_full;
        rd_data[StTxEmpty]          = tx_empty;
        rd_data[StRxFull]           = rx_full;
        rd_data[StRxEmpty]          = rx_empty;
        rd_data[StTxOvf]            = tx_ovf_q;
        rd_data[StRxUnd]            = rx_und_q;
        rd_data[StCountLsb +: 8]    = 8'(rx_count);
      end
      OffCtrl:   rd_data[CtrlLoopback] = loopback;
      OffRsvd:   rd_data = '0;
    endcase
  end

  assign yBus = (notReset && sel && !memNotRead && memNotWrite) ? rd_data : 16'hzzzz;

  assign unused_ybus = ^{yBus[15:8], tx_count_unused};

endmodule

// File: tb/tb_bus_io_port.sv
// Directed self-checking bench for bus_io_port (default BASE_ADDR 16'hFF00, FIFO_DEPTH 4).
module tb_bus_io_port;

  logic        clock = 1'b0;
  logic        notReset;
  logic [15:0] aBus;
  wire  [15:0] yBus;
  logic        memNotRead, memNotWrite;
  logic [7:0]  txData;
  logic        txValid, txReady;
  logic [7:0]  rxData;
  logic        rxValid, rxReady;
  logic [15:0] bus_drv;
  logic        bus_oe;
  logic [15:0] rd;
  int          errors = 0;
  int          checks = 0;

  localparam logic [15:0] AData = 16'hFF00, AStat = 16'hFF01, ACtrl = 16'hFF02, ARsvd = 16'hFF03;

  assign yBus = bus_oe ? bus_drv : 16'hzzzz;

  always #5 clock = ~clock;

  bus_io_port dut (
    .clock       (clock),
    .notReset    (notReset),
    .aBus        (aBus),
    .yBus        (yBus),
    .memNotRead  (memNotRead),
    .memNotWrite (memNotWrite),
    .txData      (txData),
    .txValid     (txValid),
    .txReady     (txReady),
    .rxData      (rxData),
    .rxValid     (rxValid),
    .rxReady     (rxReady)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
    aBus = addr; bus_drv = data; bus_oe = 1'b1; memNotWrite = 1'b0;
    cyc();
    memNotWrite = 1'b1; bus_oe = 1'b0;
    cyc();
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [15:0] data);
    aBus = addr; memNotRead = 1'b0;
    #1 data = yBus;
    cyc();
    memNotRead = 1'b1;
    cyc();
  endtask

  task automatic rx_push(input logic [7:0] b);
    rxValid = 1'b1; rxData = b;
    cyc();
    rxValid = 1'b0;
  endtask

  initial begin
    notReset = 1'b0; aBus = 16'h0000; memNotRead = 1'b1; memNotWrite = 1'b1;
    txReady = 1'b0; rxData = 8'h00; rxValid = 1'b0; bus_drv = 16'h0000; bus_oe = 1'b0;
    cyc(); cyc();
    check("reset_txvalid", {15'd0, txValid}, 16'h0000);
    check("reset_rxready", {15'd0, rxReady}, 16'h0001);
    check("reset_txdata", {8'd0, txData}, 16'h0000);
    notReset = 1'b1;
    cyc(); cyc();
    bus_read(AStat, rd); check("reset_status", rd, 16'h000A);

    // Single TX write
    bus_write(AData, 16'h0041);
    check("tx1_valid", {15'd0, txValid}, 16'h0001);
    check("tx1_data", {8'd0, txData}, 16'h0041);
    bus_read(AStat, rd); check("tx1_status", rd, 16'h0008);

    // Overflow on fifth write, then clear
    bus_write(AData, 16'h0042);
    bus_write(AData, 16'h0043);
    bus_write(AData, 16'h0044);
    bus_write(AData, 16'h0045);
    bus_read(AStat, rd); check("ovf_status", rd, 16'h0019);
    bus_write(ACtrl, 16'h0004);
    bus_read(AStat, rd); check("ovf_clear", rd, 16'h0009);
    txReady = 1'b1; cyc(); txReady = 1'b0;
    check("tx_drain_head", {8'd0, txData}, 16'h0042);
    bus_write(ACtrl, 16'h0001);
    check("tx_flush", {15'd0, txValid}, 16'h0000);

    // RX reads and underrun
    rx_push(8'h12); rx_push(8'h34);
    bus_read(AStat, rd); check("rx2_status", rd, 16'h0202);
    bus_read(AData, rd); check("rx_read1", rd, 16'h0012);
    bus_read(AData, rd); check("rx_read2", rd, 16'h0034);
    bus_read(AData, rd); check("rx_read_empty", rd, 16'h0000);
    bus_read(AStat, rd); check("underrun_status", rd, 16'h002A);
    bus_write(ACtrl, 16'h0004);

    // Read strobe held low three edges pops once
    rx_push(8'h55); rx_push(8'h66);
    aBus = AData; memNotRead = 1'b0;
    #1 check("hold_rd_value", yBus, 16'h0055);
    cyc(); cyc(); cyc();
    memNotRead = 1'b1; cyc();
    bus_read(AStat, rd); check("hold_rd_count", rd, 16'h0102);
    bus_read(AData, rd); check("hold_rd_next", rd, 16'h0066);

    // Both strobes low: write wins, no drive, no pop
    rx_push(8'h99);
    aBus = AData; bus_drv = 16'h0077; bus_oe = 1'b1; memNotRead = 1'b0; memNotWrite = 1'b0;
    #1 check("both_bus", yBus, 16'h0077);
    cyc();
    memNotRead = 1'b1; memNotWrite = 1'b1; bus_oe = 1'b0;
    cyc();
    check("both_txdata", {8'd0, txData}, 16'h0077);
    bus_read(AStat, rd); check("both_nopop", rd, 16'h0100);
    bus_read(AData, rd); check("both_rxhead", rd, 16'h0099);

    // Reserved offset
    bus_read(ARsvd, rd); check("rsvd_read", rd, 16'h0000);
    bus_write(ARsvd, 16'hFFFF);
    bus_read(AStat, rd); check("rsvd_write", rd, 16'h0008);

    // TX push and pop on the same edge
    aBus = AData; bus_drv = 16'h0088; bus_oe = 1'b1; memNotWrite = 1'b0; txReady = 1'b1;
    cyc();
    txReady = 1'b0; memNotWrite = 1'b1; bus_oe = 1'b0;
    cyc();
    check("tx_pushpop_head", {8'd0, txData}, 16'h0088);
    txReady = 1'b1; cyc(); txReady = 1'b0;
    check("tx_pushpop_count", {15'd0, txValid}, 16'h0000);

    // RX push and pop on the same edge
    rx_push(8'hA1);
    aBus = AData; memNotRead = 1'b0; rxValid = 1'b1; rxData = 8'hA2;
    cyc();
    rxValid = 1'b0; memNotRead = 1'b1;
    cyc();
    bus_read(AStat, rd); check("rx_pushpop_count", rd, 16'h0102);
    bus_read(AData, rd); check("rx_pushpop_head", rd, 16'h00A2);

    // RX flush on the same edge as a push
    aBus = ACtrl; bus_drv = 16'h0002; bus_oe = 1'b1; memNotWrite = 1'b0;
    rxValid = 1'b1; rxData = 8'hB0;
    cyc();
    rxValid = 1'b0; memNotWrite = 1'b1; bus_oe = 1'b0;
    cyc();
    bus_read(AStat, rd); check("flush_beats_push", rd, 16'h000A);

    // Fill RX, drop extra, drain, then wrap pointers
    rxValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rxData = 8'hC0 + 8'(i);
      cyc();
    end
    rxValid = 1'b0;
    check("rx_full_ready", {15'd0, rxReady}, 16'h0000);
    bus_read(AStat, rd); check("rx_full_status", rd, 16'h0406);
    for (int i = 0; i < 4; i++) begin
      bus_read(AData, rd); check("rx_drain", rd, 16'h00C0 + 16'(i));
    end
    rx_push(8'hD0); rx_push(8'hD1);
    bus_read(AData, rd); check("rx_wrap1", rd, 16'h00D0);
    bus_read(AData, rd); check("rx_wrap2", rd, 16'h00D1);

    // Reset mid-write with TX holding three bytes
    bus_write(AData, 16'h0001);
    bus_write(AData, 16'h0002);
    bus_write(AData, 16'h0003);
    aBus = AData; bus_drv = 16'h0004; bus_oe = 1'b1; memNotWrite = 1'b0;
    #2 notReset = 1'b0;
    #1 check("async_reset_txvalid", {15'd0, txValid}, 16'h0000);
    cyc();
    notReset = 1'b1;
    cyc(); cyc();
    check("release_low_strobe", {15'd0, txValid}, 16'h0000);
    memNotWrite = 1'b1; bus_oe = 1'b0;
    cyc();
    bus_read(AStat, rd); check("reset_mid_status", rd, 16'h000A);

`ifdef BUS_IO_LOOPBACK_EN
    bus_write(ACtrl, 16'h0008);
    bus_read(ACtrl, rd); check("ctrl_loopback", rd, 16'h0008);
    bus_write(AData, 16'h00AA);
    check("lb_txvalid", {15'd0, txValid}, 16'h0000);
    bus_read(AData, rd); check("lb_data", rd, 16'h00AA);
`else
    bus_write(ACtrl, 16'h0008);
    bus_read(ACtrl, rd); check("ctrl_no_loopback", rd, 16'h0000);
    bus_write(AData, 16'h00AA);
    check("nolb_txvalid", {15'd0, txValid}, 16'h0001);
    bus_read(AStat, rd); check("nolb_rx_empty", rd, 16'h0008);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
